// File: rtl/tx_crc_sequencer.sv
// tx_crc_sequencer
// Packet-level transmit controller. Serialises the PID byte ({~pid,pid}) and
// the payload bytes LSB first toward the bit stuffer, feeds payload bits to the
// CRC16 calculator, then appends the inverted CRC16 MSB first and flags EOP.
//
// Ports
//   clk, n_rst              clock (rising edge), asynchronous active-low reset
//   tx_start, tx_abort      packet start (IDLE only) / synchronous abort
//   pid                     PID nibble
//   data_valid/byte/last    payload source; data_ready is the accept strobe
//   crc_bit, crc_new_bit    serial bit + strobe toward the CRC calculator
//   crc_clear, crc_calc     CRC calculator reset / calculate controls
//   crc_send, crc_bytes     CRC result handshake and value
//   tx_bit, tx_bit_valid    serial output bit + qualifying strobe
//   tx_eop, busy            end-of-packet pulse, non-idle indicator
//   err_underrun            payload byte missing at a byte boundary
//   err_crc_timeout         CRC result did not arrive in time
module tx_crc_sequencer #(
  parameter int BIT_PERIOD  = 8,
  parameter int CRC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        tx_start,
  input  logic        tx_abort,
  input  logic [3:0]  pid,
  input  logic        data_valid,
  input  logic [7:0]  data_byte,
  input  logic        data_last,
  output logic        data_ready,
  output logic        crc_bit,
  output logic        crc_new_bit,
  output logic        crc_clear,
  output logic        crc_calc,
  input  logic        crc_send,
  input  logic [15:0] crc_bytes,
  output logic        tx_bit,
  output logic        tx_bit_valid,
  output logic        tx_eop,
  output logic        busy,
  output logic        err_underrun,
  output logic        err_crc_timeout
);

  localparam int BW = $clog2(BIT_PERIOD);
  localparam int WW = $clog2(CRC_TIMEOUT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_PERIOD - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(CRC_TIMEOUT);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_PID      = 3'd2,
    S_LOAD     = 3'd3,
    S_DATA     = 3'd4,
    S_CRC_WAIT = 3'd5,
    S_CRC      = 3'd6,
    S_EOP      = 3'd7
  } state_t;

  state_t        state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [4:0]    bit_cnt_r, bit_cnt_s;
  logic [WW-1:0] wait_r, wait_s;
  logic [15:0]   shreg_r, shreg_s;
  logic          last_r, last_s;
  logic          clr_pend_r, clr_pend_s;   // crc_clear owed in the cycle after an abort

  logic bit_state_s, wrap_s, emit_s, out_bit_s;

  // Bit engine decode: emit cycle and the bit currently at the shift-out end.
  always_comb begin
    bit_state_s = (state_r == S_PID) || (state_r == S_DATA) || (state_r == S_CRC);
    wrap_s      = (baud_r == BAUD_LAST);
    emit_s      = bit_state_s && wrap_s && !tx_abort;
    // PID/DATA shift out LSB first, CRC shifts out MSB first.
    if (state_r == S_CRC) out_bit_s = shreg_r[15];
    else                  out_bit_s = shreg_r[0];
  end

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    state_s    = state_r;
    baud_s     = baud_r;
    bit_cnt_s  = bit_cnt_r;
    wait_s     = wait_r;
    shreg_s    = shreg_r;
    last_s     = last_r;
    clr_pend_s = 1'b0;
    if (tx_abort) begin
      state_s    = S_IDLE;
      clr_pend_s = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (tx_start) state_s = S_CLEAR;
          else          state_s = S_IDLE;
        end
        S_CLEAR: begin
          shreg_s   = {8'h00, ~pid, pid};
          bit_cnt_s = 5'd0;
          baud_s    = {BW{1'b0}};
          state_s   = S_PID;
        end
        S_PID, S_DATA, S_CRC: begin
          if (wrap_s) begin
            baud_s    = {BW{1'b0}};
            bit_cnt_s = bit_cnt_r + 5'd1;
            if (state_r == S_CRC) begin
              shreg_s = {shreg_r[14:0], 1'b0};
              if (bit_cnt_r == 5'd15) state_s = S_EOP;
              else                    state_s = S_CRC;
            end else begin
              shreg_s = {1'b0, shreg_r[15:1]};
              if (bit_cnt_r != 5'd7) begin
                state_s = state_r;
              end else if ((state_r == S_DATA) && last_r) begin
                state_s = S_CRC_WAIT;
                wait_s  = {WW{1'b0}};
              end else begin
                state_s = S_LOAD;
              end
            end
          end else begin
            baud_s = baud_r + BAUD_ONE;
          end
        end
        S_LOAD: begin
          // Baud counter keeps running so bit spacing is unbroken across LOAD.
          baud_s = baud_r + BAUD_ONE;
          if (data_valid) begin
            shreg_s   = {8'h00, data_byte};
            last_s    = data_last;
            bit_cnt_s = 5'd0;
            state_s   = S_DATA;
          end else begin
            state_s    = S_IDLE;
            clr_pend_s = 1'b1;
          end
        end
        S_CRC_WAIT: begin
          baud_s = {BW{1'b0}};
          if (crc_send) begin
            shreg_s   = ~crc_bytes;
            bit_cnt_s = 5'd0;
            state_s   = S_CRC;
          end else if (wait_r == WAIT_LAST) begin
            state_s    = S_IDLE;
            clr_pend_s = 1'b1;
          end else begin
            wait_s = wait_r + WAIT_ONE;
          end
        end
        S_EOP: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= S_IDLE;
      baud_r     <= {BW{1'b0}};
      bit_cnt_r  <= 5'd0;
      wait_r     <= {WW{1'b0}};
      shreg_r    <= 16'h0000;
      last_r     <= 1'b0;
      clr_pend_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_r     <= baud_s;
      bit_cnt_r  <= bit_cnt_s;
      wait_r     <= wait_s;
      shreg_r    <= shreg_s;
      last_r     <= last_s;
      clr_pend_r <= clr_pend_s;
    end
  end

  // Output decode; one-cycle strobes are suppressed in an abort cycle.
  always_comb begin
    busy            = (state_r != S_IDLE);
    crc_clear       = (state_r == S_CLEAR) || clr_pend_r;
    crc_calc        = (state_r == S_CRC_WAIT) || (state_r == S_CRC);
    data_ready      = (state_r == S_LOAD) && !tx_abort;
    tx_bit_valid    = emit_s;
    tx_bit          = emit_s && out_bit_s;
    crc_new_bit     = emit_s && (state_r == S_DATA);
    crc_bit         = emit_s && (state_r == S_DATA) && out_bit_s;
    tx_eop          = (state_r == S_EOP) && !tx_abort;
    err_underrun    = (state_r == S_LOAD) && !data_valid && !tx_abort;
    err_crc_timeout = (state_r == S_CRC_WAIT) && !crc_send && (wait_r == WAIT_LAST) && !tx_abort;
  end

endmodule

// File: tb/tb_tx_crc_sequencer.sv
// Bench for tx_crc_sequencer: per-packet expected output schedule computed from
// bit-time arithmetic, compared against the DUT every cycle on the falling edge.
module tb_tx_crc_sequencer;

  localparam int BP = 4;
  localparam int TO = 64;
  localparam int F_V = 0, F_B = 1, F_R = 2, F_NB = 3, F_CB = 4, F_EOP = 5;
  localparam int F_EU = 6, F_ET = 7, F_CLR = 8, F_CALC = 9, F_BUSY = 10;
  localparam bit [10:0] STROBES = 11'h0FF;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic tx_start = 1'b0, tx_abort = 1'b0, data_valid = 1'b0, data_last = 1'b0, crc_send = 1'b0;
  logic [3:0]  pid = 4'h0;
  logic [7:0]  data_byte = 8'h00;
  logic [15:0] crc_bytes = 16'h0000;
  logic data_ready, crc_bit, crc_new_bit, crc_clear, crc_calc;
  logic tx_bit, tx_bit_valid, tx_eop, busy, err_underrun, err_crc_timeout;

  tx_crc_sequencer #(.BIT_PERIOD(BP), .CRC_TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_abort(tx_abort), .pid(pid),
    .data_valid(data_valid), .data_byte(data_byte), .data_last(data_last),
    .data_ready(data_ready), .crc_bit(crc_bit), .crc_new_bit(crc_new_bit),
    .crc_clear(crc_clear), .crc_calc(crc_calc), .crc_send(crc_send), .crc_bytes(crc_bytes),
    .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid), .tx_eop(tx_eop), .busy(busy),
    .err_underrun(err_underrun), .err_crc_timeout(err_crc_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per absolute cycle, and input drives per absolute cycle.
  bit [10:0] exp_q[int];
  bit        drv_start[int], drv_abort[int], drv_dv[int], drv_last[int], drv_send[int];
  bit [7:0]  drv_byte[int];
  bit [15:0] drv_crc[int];
  logic [7:0] pk_bytes [0:7];
  logic [31:0] mdl_bits;

  // Monitor statistics.
  logic [31:0] obs_bits = 32'd0;
  int cnt_v = 0, cnt_nb = 0, cnt_r = 0, cnt_eop = 0, cnt_eu = 0, cnt_et = 0;
  int last_ready = 0, ready_gap = 0, last_v_cyc = 0, calc_rise_gap = 0, calc_rise_cyc = 0, to_gap = 0;
  logic prev_calc = 1'b0;
  bit [10:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Per-cycle comparison against the expected schedule.
  always @(negedge clk) begin
    mon_e = exp_q.exists(cyc) ? exp_q[cyc] : 11'd0;
    chk("tx_bit_valid", 32'(tx_bit_valid), 32'(mon_e[F_V]));
    chk("tx_bit", 32'(tx_bit), 32'(mon_e[F_B]));
    chk("data_ready", 32'(data_ready), 32'(mon_e[F_R]));
    chk("crc_new_bit", 32'(crc_new_bit), 32'(mon_e[F_NB]));
    chk("crc_bit", 32'(crc_bit), 32'(mon_e[F_CB]));
    chk("tx_eop", 32'(tx_eop), 32'(mon_e[F_EOP]));
    chk("err_underrun", 32'(err_underrun), 32'(mon_e[F_EU]));
    chk("err_crc_timeout", 32'(err_crc_timeout), 32'(mon_e[F_ET]));
    chk("crc_clear", 32'(crc_clear), 32'(mon_e[F_CLR]));
    chk("crc_calc", 32'(crc_calc), 32'(mon_e[F_CALC]));
    chk("busy", 32'(busy), 32'(mon_e[F_BUSY]));
    if (crc_calc === 1'b1 && !prev_calc) begin
      calc_rise_gap = cyc - last_v_cyc;
      calc_rise_cyc = cyc;
    end
    prev_calc = (crc_calc === 1'b1);
    if (tx_bit_valid === 1'b1) begin
      cnt_v++;
      last_v_cyc = cyc;
      obs_bits = {obs_bits[30:0], tx_bit};
    end
    if (crc_new_bit === 1'b1) cnt_nb++;
    if (data_ready === 1'b1) begin
      cnt_r++;
      ready_gap = cyc - last_ready;
      last_ready = cyc;
    end
    if (tx_eop === 1'b1) cnt_eop++;
    if (err_underrun === 1'b1) cnt_eu++;
    if (err_crc_timeout === 1'b1) begin
      cnt_et++;
      to_gap = cyc - calc_rise_cyc;
    end
  end

  task automatic mark(input int c, input int f);
    bit [10:0] v;
    v = exp_q.exists(c) ? exp_q[c] : 11'd0;
    v[f] = 1'b1;
    exp_q[c] = v;
  endtask

  task automatic emit_bit(input int c, input logic b, input logic is_data);
    mark(c, F_V);
    if (b) mark(c, F_B);
    if (is_data) begin
      mark(c, F_NB);
      if (b) mark(c, F_CB);
    end
    mdl_bits = {mdl_bits[30:0], b};
  endtask

  task automatic prune(input int from);
    int ks[$];
    foreach (exp_q[k]) if (k >= from) ks.push_back(k);
    foreach (ks[i]) exp_q.delete(ks[i]);
  endtask

  // One packet: build schedule, then drive it cycle by cycle.
  // under_j: index of missing byte (-1 none); d: crc_send delay after CRC_WAIT
  // entry (-1 never); cut_mode: 0 none, 1 tx_abort, 2 n_rst at a random busy cycle.
  task automatic run_packet(input logic [3:0] p, input int n, input int under_j,
                            input int d, input int cut_mode, input logic [15:0] crc);
    int t, e_c, s_c, busy_end, a_c, lc, drv_stop, rst_at;
    logic [7:0] pid_byte, cur;
    bit [10:0] v;
    exp_q.delete(); drv_start.delete(); drv_abort.delete(); drv_dv.delete();
    drv_last.delete(); drv_send.delete(); drv_byte.delete(); drv_crc.delete();
    mdl_bits = 32'd0;
    t = cyc;
    pid = p;
    pid_byte = {~p, p};
    drv_start[t] = 1'b1;
    mark(t + 1, F_CLR);
    for (int i = 0; i < 8; i++) emit_bit(t + 1 + BP * (i + 1), pid_byte[i], 1'b0);
    busy_end = t + 1;
    e_c = -1;
    s_c = -1;
    for (int j = 0; j < n; j++) begin
      lc = t + 1 + BP * 8 * (j + 1) + 1;
      mark(lc, F_R);
      if (j == under_j) begin
        drv_dv[lc] = 1'b0;
        mark(lc, F_EU);
        mark(lc + 1, F_CLR);
        busy_end = lc;
        break;
      end
      drv_dv[lc] = 1'b1;
      drv_byte[lc] = pk_bytes[j];
      drv_last[lc] = (j == n - 1);
      cur = pk_bytes[j];
      for (int i = 0; i < 8; i++) emit_bit(t + 1 + BP * (8 + 8 * j + i + 1), cur[i], 1'b1);
    end
    if (under_j < 0) begin
      e_c = t + 1 + BP * (8 + 8 * n) + 1;
      if (d >= 0) begin
        s_c = e_c + d;
        drv_send[s_c] = 1'b1;
        drv_crc[s_c] = crc;
        for (int m = 0; m < 16; m++) emit_bit(s_c + BP * (m + 1), ~crc[15 - m], 1'b0);
        busy_end = s_c + 16 * BP + 1;
        mark(busy_end, F_EOP);
        for (int c = e_c; c < busy_end; c++) mark(c, F_CALC);
      end else begin
        busy_end = e_c + TO;
        mark(busy_end, F_ET);
        mark(busy_end + 1, F_CLR);
        for (int c = e_c; c <= busy_end; c++) mark(c, F_CALC);
      end
    end
    for (int c = t + 1; c <= busy_end; c++) begin
      mark(c, F_BUSY);
      if ($urandom_range(15, 0) == 0) drv_start[c] = 1'b1;
      if (!(e_c >= 0 && c >= e_c && (s_c < 0 || c <= s_c)) && $urandom_range(7, 0) == 0) begin
        drv_send[c] = 1'b1;
        drv_crc[c] = 16'($urandom);
      end
    end
    drv_stop = busy_end + 10;
    rst_at = -100;
    if (cut_mode != 0) begin
      a_c = t + $urandom_range(busy_end - t, 1);
      if (cut_mode == 1) begin
        prune(a_c + 1);
        v = exp_q.exists(a_c) ? exp_q[a_c] : 11'd0;
        exp_q[a_c] = v & ~STROBES;
        mark(a_c + 1, F_CLR);
        drv_abort[a_c] = 1'b1;
        drv_stop = a_c;
      end else begin
        prune(a_c);
        drv_stop = a_c - 1;
        rst_at = a_c;
      end
    end
    for (int c = t; c <= busy_end + 4; c++) begin
      if (c <= drv_stop) begin
        tx_start   = drv_start.exists(c) ? drv_start[c] : 1'b0;
        tx_abort   = drv_abort.exists(c) ? drv_abort[c] : 1'b0;
        data_valid = drv_dv.exists(c) ? drv_dv[c] : 1'($urandom_range(1, 0));
        data_byte  = drv_byte.exists(c) ? drv_byte[c] : 8'($urandom);
        data_last  = drv_last.exists(c) ? drv_last[c] : 1'($urandom_range(1, 0));
        crc_send   = drv_send.exists(c) ? drv_send[c] : 1'b0;
        crc_bytes  = drv_crc.exists(c) ? drv_crc[c] : 16'($urandom);
      end else begin
        tx_start = 1'b0; tx_abort = 1'b0; data_valid = 1'b0; crc_send = 1'b0;
      end
      if (c == rst_at + 2) n_rst = 1'b1;
      if (c == rst_at) begin
        #1;
        n_rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    tx_start = 1'b0; tx_abort = 1'b0; data_valid = 1'b0; crc_send = 1'b0;
  endtask

  int v0, nb0, r0, eop0, eu0, et0;

  task automatic snap();
    v0 = cnt_v; nb0 = cnt_nb; r0 = cnt_r; eop0 = cnt_eop; eu0 = cnt_eu; et0 = cnt_et;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({tx_bit, tx_bit_valid, tx_eop, busy, err_underrun, err_crc_timeout,
                              data_ready, crc_bit, crc_new_bit, crc_clear, crc_calc}), 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // PID 0011, one byte 0x5A, CRC 0x1234 -> inverted 0xEDCB on the wire.
    snap();
    pk_bytes[0] = 8'h5A;
    run_packet(4'b0011, 1, -1, 5, 0, 16'h1234);
    chk("dir1_wire_bits", obs_bits, 32'hC35AEDCB);
    chk("dir1_model_bits", mdl_bits, 32'hC35AEDCB);
    chk("dir1_valid_cnt", 32'(cnt_v - v0), 32'd32);
    chk("dir1_newbit_cnt", 32'(cnt_nb - nb0), 32'd8);
    chk("dir1_eop_cnt", 32'(cnt_eop - eop0), 32'd1);

    // Three bytes, last on the third.
    snap();
    pk_bytes[0] = 8'h01; pk_bytes[1] = 8'h80; pk_bytes[2] = 8'hFF;
    run_packet(4'hA, 3, -1, 9, 0, 16'hBEEF);
    chk("dir2_ready_cnt", 32'(cnt_r - r0), 32'd3);
    chk("dir2_ready_gap", 32'(ready_gap), 32'd32);
    chk("dir2_valid_cnt", 32'(cnt_v - v0), 32'd48);
    chk("dir2_newbit_cnt", 32'(cnt_nb - nb0), 32'd24);
    chk("dir2_calc_rise", 32'(calc_rise_gap), 32'd1);

    // Underrun at the second LOAD.
    snap();
    run_packet(4'h5, 3, 1, 0, 0, 16'h0000);
    chk("dir3_underrun_cnt", 32'(cnt_eu - eu0), 32'd1);
    chk("dir3_eop_cnt", 32'(cnt_eop - eop0), 32'd0);

    // crc_send never arrives.
    snap();
    run_packet(4'h9, 2, -1, -1, 0, 16'h0000);
    chk("dir4_timeout_cnt", 32'(cnt_et - et0), 32'd1);
    chk("dir4_timeout_gap", 32'(to_gap), 32'd64);
    chk("dir4_eop_cnt", 32'(cnt_eop - eop0), 32'd0);

    // tx_start together with tx_abort in IDLE: stay idle, clear next cycle.
    exp_q.delete();
    mark(cyc + 1, F_CLR);
    tx_start = 1'b1; tx_abort = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0; tx_abort = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Randomised packets, including aborts and mid-packet resets.
    for (int r = 0; r < 40; r++) begin
      int n, uj, dd, cm, x;
      n = $urandom_range(5, 1);
      for (int j = 0; j < n; j++) pk_bytes[j] = 8'($urandom);
      uj = ($urandom_range(9, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      dd = ($urandom_range(9, 0) == 0) ? -1 : int'($urandom_range(60, 0));
      x = $urandom_range(19, 0);
      cm = (x < 3) ? 1 : ((x < 5) ? 2 : 0);
      run_packet(4'($urandom), n, uj, dd, cm, 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_crc_sequencer.md
# tx_crc_sequencer

Packet-level controller for the transmit CRC path. It serializes the PID byte and the data bytes into the bit stream headed for the bit stuffer. In parallel it drives the CRC16 calculator's bit/strobe/reset/calc controls, then appends the inverted CRC16 and flags end of packet. It sits between the TX data FIFO and the bit stuffer, and is the only master of the CRC calculator.

## Interface
- BIT_PERIOD, 8, clocks per emitted bit (≥4)
- CRC_TIMEOUT, 64, max clocks to wait for crc_send after crc_calc rises (≥40)
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous reset, active low
- tx_start  in  1  start packet; sampled in IDLE only
- tx_abort  in  1  synchronous abort; priority over everything except n_rst
- pid  in  4  PID nibble; PID byte = {~pid, pid}
- data_valid  in  1  data_byte/data_last valid
- data_byte  in  8  payload byte, sent LSB first
- data_last  in  1  marks final payload byte
- data_ready  out  1  one-cycle accept strobe (valid & ready = byte taken)
- crc_bit  out  1  to CRC bit_in
- crc_new_bit  out  1  to CRC new_bit, one-cycle strobe per data bit
- crc_clear  out  1  to CRC synchronous reset
- crc_calc  out  1  to CRC_Calc
- crc_send  in  1  from CRC_Send; CRC result ready
- crc_bytes  in  16  from CRC_Bytes
- tx_bit  out  1  serial bit to bit stuffer
- tx_bit_valid  out  1  one-cycle strobe qualifying tx_bit
- tx_eop  out  1  one-cycle pulse after last CRC bit
- busy  out  1  high in every state except IDLE
- err_underrun  out  1  one-cycle pulse, data missing at byte boundary
- err_crc_timeout  out  1  one-cycle pulse, crc_send never arrived

## Operation
- States: IDLE, CLEAR, PID, LOAD, DATA, CRC_WAIT, CRC, EOP.
- IDLE: all outputs 0. tx_start=1 moves to CLEAR.
- CLEAR (1 cycle): crc_clear=1. Load 8-bit shift reg with {~pid,pid}, bit_cnt=0, baud_cnt=0. Go to PID.
- Bit engine (PID, DATA, CRC): baud_cnt counts 0..BIT_PERIOD-1 and wraps. On the wrap cycle: tx_bit=shreg LSB (PID/DATA) or MSB (CRC), tx_bit_valid=1, shift, bit_cnt++.
- PID bits are not fed to the CRC. In DATA, on each emit cycle crc_bit=tx_bit and crc_new_bit=1.
- After PID bit 8, or DATA bit 8 when the byte was not last, go to LOAD.
- LOAD (1 cycle, baud_cnt keeps running): data_ready=1.
  - data_valid=1: capture data_byte and data_last, bit_cnt=0, go to DATA.
  - data_valid=0: err_underrun=1, then abort sequence.
- After DATA bit 8 of a last byte: go to CRC_WAIT with crc_calc=1. crc_calc stays high through CRC_WAIT and CRC.
- CRC_WAIT: baud_cnt held at 0 and wait_cnt counts.
  - crc_send=1: latch ~crc_bytes into the 16-bit shift reg, go to CRC.
  - wait_cnt reaches CRC_TIMEOUT: err_crc_timeout=1, then abort sequence.
- CRC: emit 16 bits MSB first (~crc_bytes[15] first). After bit 16 go to EOP.
- EOP (1 cycle): tx_eop=1, crc_calc=0. Go to IDLE.
- Abort sequence (tx_abort, underrun, timeout): next state IDLE. crc_clear=1 and crc_calc=0 in the cycle after the abort condition. No tx_eop.
- Packets carry ≥1 data byte. Zero-length packets are not handled by this block.
- tx_bit_valid strobes are not strictly periodic: a gap occurs during CRC_WAIT, and downstream consumes bits by strobe.

## Timing
- Reset: state IDLE, shift regs and all counters 0, every output 0.
- tx_start at cycle T gives CLEAR at T+1 and the first tx_bit_valid at T+1+BIT_PERIOD.
- Bit N+1 follows bit N by exactly BIT_PERIOD cycles within PID/DATA, including across LOAD.
- The first CRC bit comes BIT_PERIOD cycles after the crc_send latch cycle.
- tx_eop comes 1 cycle after the 16th CRC bit.
- Strobe counts per packet with N bytes: tx_bit_valid = 8+8N+16, crc_new_bit = 8N, data_ready = N.
- tx_start while busy is ignored. tx_start together with tx_abort in IDLE: abort wins, stays IDLE.
- crc_send while not in CRC_WAIT is ignored.
- Reset mid-packet: outputs 0 immediately (async). No eop or error pulses afterwards.

## Test plan
- BIT_PERIOD=4, pid=4'b0011, one byte 0x5A last, model returns crc_bytes=16'h1234 → tx_bit sequence 1,1,0,0,0,0,1,1 | 0,1,0,1,1,0,1,0 | 1110110111001011 (0xEDCB MSB first), crc_new_bit exactly 8 times, then tx_eop.
- Three bytes 0x01,0x80,0xFF, last on third → data_ready pulses 3 times, 32 cycles apart at BIT_PERIOD=4; 48 tx_bit_valid total; crc_calc rises the cycle after data bit 24.
- data_valid low at second LOAD → err_underrun single pulse, crc_clear pulse, busy=0 next cycle, no tx_eop.
- crc_send never asserted, CRC_TIMEOUT=64 → err_crc_timeout 64 cycles after CRC_WAIT entry, then IDLE with crc_clear.
- n_rst low mid-DATA → all outputs 0 that cycle. tx_abort mid-CRC → IDLE, no further tx_bit_valid.
- tx_start pulsed during DATA → no effect on bit stream or strobe counts.
